// File: rtl/bayer_mosaic.sv
// bayer_mosaic: raster RGB stream to single-channel Bayer stream, followed by
// zero flush rows and a one-cycle done pulse per frame.
module bayer_mosaic #(
    parameter int width      = 320,
    parameter int height     = 240,
    parameter int FLUSH_ROWS = 2,
    parameter int PATTERN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iR,
    input  logic [7:0] iG,
    input  logic [7:0] iB,
    input  logic       iValid,
    output logic       oReady,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oDone
);
    localparam int F      = width * FLUSH_ROWS;
    localparam int F_LAST = F > 0 ? F - 1 : 0;
    localparam int XW     = width > 1 ? $clog2(width) : 1;
    localparam int YW     = height > 1 ? $clog2(height) : 1;
    localparam int FW     = F > 1 ? $clog2(F) : 1;
    // Red sits at {y[0],x[0]} == PATTERN and blue diagonally opposite; green fills the rest.
    localparam logic [1:0] R_POS = 2'(PATTERN);

    typedef enum logic [1:0] {ACTIVE, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [FW-1:0] f_q, f_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          accept, last_x, last_px;
    logic [1:0]    pos;
    logic [7:0]    pix;

    assign oReady = (state_q == ACTIVE) && !reset;
    assign oData  = data_q;
    assign oValid = valid_q;
    assign oDone  = done_q;

    always_comb begin
        accept  = iValid && oReady;
        last_x  = x_q == XW'(width - 1);
        last_px = last_x && (y_q == YW'(height - 1));
        pos     = {y_q[0], x_q[0]};
        pix     = pos == R_POS ? iR : pos == ~R_POS ? iB : iG;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        f_d     = f_q;
        data_d  = 8'd0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ACTIVE: if (accept) begin
                data_d  = pix;
                valid_d = 1'b1;
                x_d     = last_x ? '0 : x_q + 1'b1;
                y_d     = last_px ? '0 : last_x ? y_q + 1'b1 : y_q;
                if (last_px) state_d = F == 0 ? DONE : FLUSH;
            end
            FLUSH: begin
                valid_d = 1'b1;
                f_d     = f_q + 1'b1;
                if (f_q == FW'(F_LAST)) state_d = DONE;
            end
            default: begin
                done_d  = 1'b1;
                x_d     = '0;
                y_d     = '0;
                f_d     = '0;
                state_d = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
            f_q     <= '0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            f_q     <= f_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_bayer_mosaic.sv
// tb_bayer_mosaic: directed checks of three 4x2 bayer_mosaic configurations
// (RGGB no flush, BGGR no flush, RGGB with two flush rows).
module tb_bayer_mosaic;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] iR, iG, iB;
    logic       v_ab, v_c;
    logic       ready_a, valid_a, done_a, ready_b, valid_b, done_b, ready_c, valid_c, done_c;
    logic [7:0] data_a, data_b, data_c;
    int         total = 0;
    int         bad = 0;

    logic [7:0] exp_rggb [8] = '{8'h10, 8'h41, 8'h12, 8'h43, 8'h44, 8'h85, 8'h46, 8'h87};
    logic [7:0] exp_bggr [8] = '{8'h80, 8'h41, 8'h82, 8'h43, 8'h44, 8'h15, 8'h46, 8'h17};
    logic [7:0] exp_f2   [8] = '{8'h20, 8'h51, 8'h22, 8'h53, 8'h54, 8'h95, 8'h56, 8'h97};

    always #5 clk = ~clk;

    bayer_mosaic #(.width(4), .height(2), .FLUSH_ROWS(0), .PATTERN(0)) u_a (
        .clk(clk), .reset(reset), .iR(iR), .iG(iG), .iB(iB), .iValid(v_ab),
        .oReady(ready_a), .oData(data_a), .oValid(valid_a), .oDone(done_a));
    bayer_mosaic #(.width(4), .height(2), .FLUSH_ROWS(0), .PATTERN(3)) u_b (
        .clk(clk), .reset(reset), .iR(iR), .iG(iG), .iB(iB), .iValid(v_ab),
        .oReady(ready_b), .oData(data_b), .oValid(valid_b), .oDone(done_b));
    bayer_mosaic #(.width(4), .height(2), .FLUSH_ROWS(2), .PATTERN(0)) u_c (
        .clk(clk), .reset(reset), .iR(iR), .iG(iG), .iB(iB), .iValid(v_c),
        .oReady(ready_c), .oData(data_c), .oValid(valid_c), .oDone(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int i, input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0);
        iR = r0 + 8'(i);
        iG = g0 + 8'(i);
        iB = b0 + 8'(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int cyc;
        logic v;
        reset = 1'b1; v_ab = 1'b0; v_c = 1'b0; iR = 8'h0; iG = 8'h0; iB = 8'h0;
        step();
        step();
        chk("rst_data", 32'(data_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_ready", 32'(ready_a), 0);
        chk("rst_valid_c", 32'(valid_c), 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(ready_a), 1);

        v_ab = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_px(k, 8'h10, 8'h40, 8'h80);
            step();
            chk("rggb_data", 32'(data_a), 32'(exp_rggb[k]));
            chk("rggb_valid", 32'(valid_a), 1);
            chk("bggr_data", 32'(data_b), 32'(exp_bggr[k]));
            chk("rggb_no_done", 32'(done_a), 0);
        end
        v_ab = 1'b0;
        chk("done_state_ready", 32'(ready_a), 0);
        step();
        chk("rggb_done", 32'(done_a), 1);
        chk("rggb_done_valid", 32'(valid_a), 0);
        chk("rggb_done_ready", 32'(ready_a), 1);
        chk("bggr_done", 32'(done_b), 1);
        step();
        chk("done_one_cycle", 32'(done_a), 0);

        v_c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_px(k, 8'h10, 8'h40, 8'h80);
            step();
            chk("flush_cfg_data", 32'(data_c), 32'(exp_rggb[k]));
            chk("flush_cfg_valid", 32'(valid_c), 1);
        end
        iR = 8'hEE; iG = 8'hEE; iB = 8'hEE;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("flush_zero", 32'(data_c), 0);
            chk("flush_valid", 32'(valid_c), 1);
            chk("flush_ready", 32'(ready_c), 0);
            chk("flush_no_done", 32'(done_c), 0);
        end
        set_px(0, 8'h20, 8'h50, 8'h90);
        step();
        chk("flush_done", 32'(done_c), 1);
        chk("flush_done_valid", 32'(valid_c), 0);
        chk("flush_done_ready", 32'(ready_c), 1);
        for (int k = 0; k < 8; k++) begin
            set_px(k, 8'h20, 8'h50, 8'h90);
            step();
            chk("b2b_data", 32'(data_c), 32'(exp_f2[k]));
            chk("b2b_valid", 32'(valid_c), 1);
            chk("b2b_no_done", 32'(done_c), 0);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            chk("b2b_flush_zero", 32'(data_c), 0);
        end
        v_c = 1'b0;
        step();
        chk("b2b_second_done", 32'(done_c), 1);

        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 200) begin
            v = 1'($urandom_range(0, 1));
            set_px(i, 8'h10, 8'h40, 8'h80);
            v_ab = v;
            step();
            chk("gap_valid", 32'(valid_a), 32'(v));
            if (v) begin
                chk("gap_data", 32'(data_a), 32'(exp_rggb[i]));
                chk("gap_data_b", 32'(data_b), 32'(exp_bggr[i]));
                i++;
            end
            cyc++;
        end
        if (i < 8) chk("gap_timeout", 32'(i), 8);
        v_ab = 1'b0;
        step();
        chk("gap_done", 32'(done_a), 1);

        v_ab = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_px(k, 8'h10, 8'h40, 8'h80);
            step();
            chk("pre_rst_data", 32'(data_a), 32'(exp_rggb[k]));
        end
        reset = 1'b1;
        set_px(5, 8'h10, 8'h40, 8'h80);
        step();
        chk("mid_rst_data", 32'(data_a), 0);
        chk("mid_rst_valid", 32'(valid_a), 0);
        chk("mid_rst_done", 32'(done_a), 0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_px(k, 8'h10, 8'h40, 8'h80);
            step();
            chk("post_rst_data", 32'(data_a), 32'(exp_rggb[k]));
            chk("post_rst_no_done", 32'(done_a), 0);
        end
        v_ab = 1'b0;
        step();
        chk("post_rst_done", 32'(done_a), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bayer_mosaic.md
# bayer_mosaic

Converts a raster-order RGB pixel stream into a single-channel 8-bit Bayer stream. It is the inverse of the demosaic stage and sits in the ISP loopback/test path, producing raw sensor-format frames from RGB sources. After each frame it appends zero-valued flush rows so a downstream row-buffered demosaic can drain its line buffers. Frame completion is signalled with a one-cycle done pulse.

## Interface
- width, 320, active pixels per row
- height, 240, active rows per frame
- FLUSH_ROWS, 2, zero rows appended after each frame (0 allowed)
- PATTERN, 0, 2x2 Bayer order at (x=0,y=0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- iR  in  8  red component
- iG  in  8  green component
- iB  in  8  blue component
- iValid  in  1  input pixel present
- oReady  out  1  block accepts a pixel this cycle
- oData  out  8  Bayer sample
- oValid  out  1  oData valid this cycle
- oDone  out  1  one-cycle pulse after the last flush word of a frame

## Operation
- Pixel accepted on a rising edge when iValid && oReady; there is no downstream backpressure.
- Counters x (0..width-1) and y (0..height-1) advance once per accepted pixel. When x=width-1, x wraps to 0 and y increments.
- Channel select uses {y[0],x[0]} and PATTERN. For RGGB: 00→R, 01→G, 10→G, 11→B. GRBG, GBRG and BGGR are the corresponding permutations: 00 gives the first letter, 01 the second, 10 the third, 11 the fourth.
- The selected 8-bit component is passed through unmodified; there is no arithmetic.
- FSM:
  - ACTIVE: oReady=1. Accepting the pixel at (width-1, height-1) moves to FLUSH, or to DONE if FLUSH_ROWS=0.
  - FLUSH: oReady=0. A flush counter runs for width*FLUSH_ROWS cycles, emitting oData=0 with oValid=1 every cycle, then moves to DONE.
  - DONE: lasts 1 cycle, oReady=0. It registers oDone=1, clears x, y and the flush counter, then moves to ACTIVE.
- oReady is combinational: (state==ACTIVE) && !reset.
- Reset, including mid-frame: state goes to ACTIVE; x, y and the flush counter clear; oData=0, oValid=0, oDone=0. The partial frame is discarded and no oDone is issued for it.
- iValid held low in ACTIVE: counters hold and oValid=0 next cycle. Gaps between input pixels are allowed anywhere in a frame.
- Input values presented while oReady=0 are ignored and not counted.

## Timing
- Latency: 1 cycle. A pixel accepted at edge T appears on oData/oValid during cycle T+1.
- oValid is registered: high in cycle T+1 iff a pixel was accepted at T or state was FLUSH at T.
- Last pixel accepted at T, with F = width*FLUSH_ROWS:
  - Last pixel is output in cycle T+1.
  - Flush zeros are output in cycles T+2..T+F+1, contiguous.
  - oDone=1 and oValid=0 in cycle T+F+2.
  - oReady is high again from cycle T+F+2, so the next frame's first pixel can be accepted in the same cycle oDone pulses.
- Output stream per frame: exactly width*(height+FLUSH_ROWS) words with oValid=1.
- All outputs are registered except oReady.

## Test plan
- RGGB, width=4, height=2, FLUSH_ROWS=0. Feed continuous pixels with iR=0x10+i, iG=0x40+i, iB=0x80+i for i=0..7. Expect oData sequence 10,41,12,43,44,85,46,87, then oDone in the cycle after 87.
- PATTERN=3 (BGGR), same stimulus. Expect 80,41,82,43,44,15,46,17.
- width=4, height=2, FLUSH_ROWS=2, continuous input. Expect 8 data words, then 8 zero words with oValid=1 and oReady=0, then oDone with oValid=0 in the next cycle and oReady=1 in that same cycle.
- Random iValid gaps (~50%) over a 4x2 frame. Expect an identical oData sequence with oValid only on the cycle after each acceptance, and counters unchanged during gaps.
- Assert reset at pixel 5 of 8, then send a full frame. Expect outputs 0 the cycle after reset, no oDone for the aborted frame, and the new frame's first output is the (0,0) channel.
- Two back-to-back frames with iValid held high. Expect the second frame's first pixel accepted in the oDone cycle, no lost or duplicated pixels, and two oDone pulses.
